serial2parallel: RTL and testbench
==================================

# serial2parallel

Receive-side companion to the transmit serializer. Takes the recovered serial bit stream, one bit per `serial_valid` strobe, and hunts for a framing sync word. Once locked, it assembles WIDTH-bit words MSB-first and emits each with a one-cycle `parallel_valid` pulse. It checks the sync word once per frame, rides through isolated sync misses, and drops lock after MAX_MISS consecutive misses.

## Interface
Parameters:
- WIDTH, 2, output word width; ≥2.
- SYNC_LEN, 8, sync word length in bits; ≥2.
- SYNC_WORD, 8'hE2, sync pattern. Transmitted MSB (bit SYNC_LEN-1) first.
- FRAME_WORDS, 16, data words between consecutive sync words; ≥1.
- MAX_MISS, 3, consecutive sync mismatches that cause loss of lock; ≥1.

Ports:
- clk_sig  in  1  single clock; all logic on its rising edge.
- reset_sig  in  1  synchronous, active-high reset.
- serial_sig  in  1  serial data bit; sampled only when serial_valid=1.
- serial_valid  in  1  bit strobe; may be low for any number of cycles between bits.
- parallel_sig  out  WIDTH  last assembled word; first-received bit in [WIDTH-1]. Holds its value between words.
- parallel_valid  out  1  one-cycle pulse when parallel_sig is updated.
- lock_sig  out  1  high in LOCK and CHECK states.
- sync_err  out  1  one-cycle pulse on a sync mismatch in CHECK.

## Operation
- Bit event: a cycle with serial_valid=1. When serial_valid=0, all state and counters hold, and parallel_valid and sync_err are 0.
- Reset (reset_sig=1 at an edge):
  - state=HUNT.
  - parallel_sig=0, parallel_valid=0, lock_sig=0, sync_err=0.
  - Sync shift register, fill count, bit_cnt, word_cnt and miss_cnt all cleared.
  - Reset overrides any bit event in the same cycle and discards any partial word.
- HUNT:
  - Each bit event shifts serial_sig into the LSB of the sync shift register and increments the fill count, saturating at SYNC_LEN.
  - Match condition: fill count ≥ SYNC_LEN-1 and {sr[SYNC_LEN-2:0], serial_sig} == SYNC_WORD.
  - On match: go to LOCK with bit_cnt=0, word_cnt=0, miss_cnt=0.
  - On entry to HUNT, the fill count is cleared, so a match needs SYNC_LEN fresh bits.
- LOCK:
  - Each bit event shifts serial_sig into the word shift register, MSB-first, and increments bit_cnt.
  - On the event with bit_cnt==WIDTH-1: parallel_sig <= {word_sr[WIDTH-2:0], serial_sig}, parallel_valid pulses, bit_cnt=0, word_cnt increments.
  - If that word was word FRAME_WORDS-1: go to CHECK with bit_cnt=0 and word_cnt=0.
- CHECK:
  - Collect SYNC_LEN bits, counting them in bit_cnt. No parallel_valid pulses.
  - On the SYNC_LEN-th bit, compare the collected bits with SYNC_WORD.
  - Match: miss_cnt=0, go to LOCK.
  - Mismatch: sync_err pulses and miss_cnt increments. If the new miss_cnt == MAX_MISS, go to HUNT and clear miss_cnt; otherwise go to LOCK with framing kept (flywheel).
- Counter widths:
  - bit_cnt: $clog2(max(WIDTH,SYNC_LEN)+1).
  - word_cnt: $clog2(FRAME_WORDS+1).
  - miss_cnt: $clog2(MAX_MISS+1).
  - Counters never wrap past their terminal values.
- lock_sig is registered. It is 1 exactly while the state register is LOCK or CHECK.

## Timing
- All outputs are registered and change only on the rising edge of clk_sig.
- Word latency: parallel_sig and parallel_valid update on the edge that samples the word's last bit. parallel_valid is high for that one following cycle only.
- Lock latency: lock_sig rises on the edge that samples the last sync bit. The first data bit can arrive on the very next bit event, including the next cycle.
- Loss of lock: lock_sig falls on the edge that samples the last bit of the MAX_MISS-th mismatching sync word, the same edge as the sync_err pulse.
- Back-to-back bit events (serial_valid held high) are supported at full clock rate. With WIDTH=2 this gives a parallel_valid every 2 cycles.
- The minimum frame is SYNC_LEN + WIDTH·FRAME_WORDS bit events.

## Test plan
- Reset: hold reset_sig=1 for 3 cycles with random serial input -> parallel_sig=0, parallel_valid=0, lock_sig=0, sync_err=0. Release; the DUT remains in HUNT until sync.
- Lock and data: send continuous valid bits 8'hE2 followed by data 2'b10, 2'b01, 2'b11 -> lock_sig=1 after the 8th bit. parallel_valid pulses on the 10th, 12th and 14th bits with parallel_sig=2, 1, 3.
- Strobe gaps: repeat the previous case with serial_valid=0 for 1–5 random cycles between bits -> identical words and order, and no extra parallel_valid pulses.
- Flywheel: after lock, send 16 words, then sync byte 8'h00, then 16 words, then 8'hE2 -> one sync_err pulse, lock_sig stays 1, all 32 words are delivered, and miss_cnt is 0 after the good sync.
- Loss of lock: send 3 consecutive frames with bad sync -> sync_err pulses 3 times and lock_sig=0 after the 3rd. A later 8'hE2 relocks, with no false match during the first 7 bits after entering HUNT.
- Reset mid-word: assert reset_sig for 1 cycle after 1 bit of a word -> lock_sig=0 next cycle and the partial word is never emitted.

Source files
------------

// File: rtl/serial2parallel.sv
// serial2parallel: receive-side deserializer with sync-word framing.
// Hunts for SYNC_WORD in the serial stream, then assembles WIDTH-bit words
// MSB-first, re-checks the sync word once per frame and tolerates up to
// MAX_MISS-1 consecutive sync misses before falling back to hunting.
module serial2parallel #(
    parameter int                  WIDTH       = 2,
    parameter int                  SYNC_LEN    = 8,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD   = 8'hE2,
    parameter int                  FRAME_WORDS = 16,
    parameter int                  MAX_MISS    = 3
) (
    input  logic             clk_sig,
    input  logic             reset_sig,
    input  logic             serial_sig,
    input  logic             serial_valid,
    output logic [WIDTH-1:0] parallel_sig,
    output logic             parallel_valid,
    output logic             lock_sig,
    output logic             sync_err
);

    localparam int BIT_MAX = (WIDTH > SYNC_LEN) ? WIDTH : SYNC_LEN;
    localparam int BCW     = $clog2(BIT_MAX + 1);
    localparam int WCW     = $clog2(FRAME_WORDS + 1);
    localparam int MCW     = $clog2(MAX_MISS + 1);
    localparam int FCW     = $clog2(SYNC_LEN + 1);

    localparam logic [BCW-1:0] WORD_LAST  = BCW'(WIDTH - 1);
    localparam logic [BCW-1:0] SYNC_LAST  = BCW'(SYNC_LEN - 1);
    localparam logic [WCW-1:0] FRAME_LAST = WCW'(FRAME_WORDS - 1);
    localparam logic [MCW-1:0] MISS_LIMIT = MCW'(MAX_MISS);
    localparam logic [FCW-1:0] FILL_FULL  = FCW'(SYNC_LEN);
    localparam logic [FCW-1:0] FILL_ARMED = FCW'(SYNC_LEN - 1);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LOCK  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t              state_q,    state_d;
    logic [SYNC_LEN-1:0] syncSr_q,   syncSr_d;
    logic [FCW-1:0]      fillCnt_q,  fillCnt_d;
    logic [WIDTH-1:0]    wordSr_q,   wordSr_d;
    logic [BCW-1:0]      bitCnt_q,   bitCnt_d;
    logic [WCW-1:0]      wordCnt_q,  wordCnt_d;
    logic [MCW-1:0]      missCnt_q,  missCnt_d;
    logic [WIDTH-1:0]    parWord_q,  parWord_d;
    logic                parValid_q, parValid_d;
    logic                lock_q,     lock_d;
    logic                syncErr_q,  syncErr_d;

    // The incoming bit appended to each shift register, used both for the
    // shift itself and for the match / word-complete decisions this cycle.
    logic [SYNC_LEN-1:0] syncShifted;
    logic [WIDTH-1:0]    wordShifted;
    logic [MCW-1:0]      missInc;

    assign syncShifted = {syncSr_q[SYNC_LEN-2:0], serial_sig};
    assign wordShifted = {wordSr_q[WIDTH-2:0], serial_sig};
    assign missInc     = missCnt_q + 1'b1;

    // Next-state logic: everything holds unless a bit event arrives.
    always_comb begin
        state_d    = state_q;
        syncSr_d   = syncSr_q;
        fillCnt_d  = fillCnt_q;
        wordSr_d   = wordSr_q;
        bitCnt_d   = bitCnt_q;
        wordCnt_d  = wordCnt_q;
        missCnt_d  = missCnt_q;
        parWord_d  = parWord_q;
        parValid_d = 1'b0;
        syncErr_d  = 1'b0;

        if (serial_valid) begin
            case (state_q)
                HUNT: begin
                    syncSr_d = syncShifted;
                    if (fillCnt_q != FILL_FULL) begin
                        fillCnt_d = fillCnt_q + 1'b1;
                    end
                    if ((fillCnt_q >= FILL_ARMED) && (syncShifted == SYNC_WORD)) begin
                        state_d   = LOCK;
                        bitCnt_d  = '0;
                        wordCnt_d = '0;
                        missCnt_d = '0;
                    end
                end

                LOCK: begin
                    wordSr_d = wordShifted;
                    if (bitCnt_q == WORD_LAST) begin
                        parWord_d  = wordShifted;
                        parValid_d = 1'b1;
                        bitCnt_d   = '0;
                        if (wordCnt_q == FRAME_LAST) begin
                            state_d   = CHECK;
                            wordCnt_d = '0;
                        end else begin
                            wordCnt_d = wordCnt_q + 1'b1;
                        end
                    end else begin
                        bitCnt_d = bitCnt_q + 1'b1;
                    end
                end

                CHECK: begin
                    syncSr_d = syncShifted;
                    if (bitCnt_q == SYNC_LAST) begin
                        bitCnt_d = '0;
                        if (syncShifted == SYNC_WORD) begin
                            missCnt_d = '0;
                            state_d   = LOCK;
                        end else begin
                            syncErr_d = 1'b1;
                            if (missInc == MISS_LIMIT) begin
                                state_d   = HUNT;
                                missCnt_d = '0;
                                fillCnt_d = '0;
                            end else begin
                                missCnt_d = missInc;
                                state_d   = LOCK;
                            end
                        end
                    end else begin
                        bitCnt_d = bitCnt_q + 1'b1;
                    end
                end

                default: begin
                    state_d   = HUNT;
                    fillCnt_d = '0;
                end
            endcase
        end

        lock_d = (state_d != HUNT);
    end

    // State and output registers with synchronous reset that wins over any bit event.
    always_ff @(posedge clk_sig) begin
        if (reset_sig) begin
            state_q    <= HUNT;
            syncSr_q   <= '0;
            fillCnt_q  <= '0;
            wordSr_q   <= '0;
            bitCnt_q   <= '0;
            wordCnt_q  <= '0;
            missCnt_q  <= '0;
            parWord_q  <= '0;
            parValid_q <= 1'b0;
            lock_q     <= 1'b0;
            syncErr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            syncSr_q   <= syncSr_d;
            fillCnt_q  <= fillCnt_d;
            wordSr_q   <= wordSr_d;
            bitCnt_q   <= bitCnt_d;
            wordCnt_q  <= wordCnt_d;
            missCnt_q  <= missCnt_d;
            parWord_q  <= parWord_d;
            parValid_q <= parValid_d;
            lock_q     <= lock_d;
            syncErr_q  <= syncErr_d;
        end
    end

    assign parallel_sig   = parWord_q;
    assign parallel_valid = parValid_q;
    assign lock_sig       = lock_q;
    assign sync_err       = syncErr_q;

endmodule

// File: tb/tb_serial2parallel.sv
// Testbench for serial2parallel: streams of bits with per-bit expectations for
// lock and sync_err, plus a queue of expected words popped on each word pulse.
module tb_serial2parallel;

    localparam int         W      = 2;
    localparam logic [7:0] SYNC   = 8'hE2;
    localparam int         FRAME  = 16;

    logic         clk_sig = 1'b0;
    logic         reset_sig = 1'b0;
    logic         serial_sig = 1'b0;
    logic         serial_valid = 1'b0;
    logic [W-1:0] parallel_sig;
    logic         parallel_valid;
    logic         lock_sig;
    logic         sync_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic         b;
        logic         rst;
        logic         push;
        logic [W-1:0] word;
        logic         expLock;
        logic         expErr;
    } item_t;

    item_t        stream[$];
    logic [W-1:0] expQ[$];

    serial2parallel #(
        .WIDTH(W), .SYNC_LEN(8), .SYNC_WORD(SYNC), .FRAME_WORDS(FRAME), .MAX_MISS(3)
    ) dut (
        .clk_sig(clk_sig),
        .reset_sig(reset_sig),
        .serial_sig(serial_sig),
        .serial_valid(serial_valid),
        .parallel_sig(parallel_sig),
        .parallel_valid(parallel_valid),
        .lock_sig(lock_sig),
        .sync_err(sync_err)
    );

    // Free-running clock.
    always #5 clk_sig = ~clk_sig;

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish by 200000, required finish earlier");
        $fatal(1);
    end

    // Append n bits of v (MSB first); only the last bit may carry a lock change or a sync error.
    task automatic addBits(input logic [31:0] v, input int n, input logic lockMid,
                           input logic lockLast, input logic errLast);
        for (int i = n - 1; i >= 0; i--) begin
            item_t it;
            it.b       = v[i];
            it.rst     = 1'b0;
            it.push    = 1'b0;
            it.word    = '0;
            it.expLock = (i == 0) ? lockLast : lockMid;
            it.expErr  = (i == 0) ? errLast : 1'b0;
            stream.push_back(it);
        end
    endtask

    // Append one data word while locked; its last bit must produce the word pulse.
    task automatic addWord(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) begin
            item_t it;
            it.b       = w[i];
            it.rst     = 1'b0;
            it.push    = (i == 0);
            it.word    = w;
            it.expLock = 1'b1;
            it.expErr  = 1'b0;
            stream.push_back(it);
        end
    endtask

    // Append a bit event that coincides with reset.
    task automatic addReset(input logic b);
        item_t it;
        it.b       = b;
        it.rst     = 1'b1;
        it.push    = 1'b0;
        it.word    = '0;
        it.expLock = 1'b0;
        it.expErr  = 1'b0;
        stream.push_back(it);
    endtask

    // Drive one bit event, sample outputs after its edge, then idle for gap cycles
    // while counting any pulses that appear during the idle cycles.
    task automatic applyStimulus(input logic b, input logic rst, input int gap,
                                 output logic pv, output logic [W-1:0] pw,
                                 output logic lk, output logic se, output int gapHits);
        serial_sig   = b;
        serial_valid = 1'b1;
        reset_sig    = rst;
        @(negedge clk_sig);
        pv = parallel_valid;
        pw = parallel_sig;
        lk = lock_sig;
        se = sync_err;
        serial_valid = 1'b0;
        reset_sig    = 1'b0;
        gapHits      = 0;
        repeat (gap) begin
            @(negedge clk_sig);
            if (parallel_valid !== 1'b0 || sync_err !== 1'b0) gapHits++;
        end
    endtask

    // One-cycle reset with no bit event, and fresh stream/scoreboard.
    task automatic doReset();
        serial_valid = 1'b0;
        reset_sig    = 1'b1;
        @(negedge clk_sig);
        reset_sig = 1'b0;
        stream.delete();
        expQ.delete();
    endtask

    task automatic test_reset();
        logic         pv, lk, se;
        logic [W-1:0] pw;
        int           gh;
        logic [7:0]   probe = 8'b1110_0011;
        reset_sig    = 1'b1;
        serial_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            serial_sig = 1'($urandom());
            @(negedge clk_sig);
            total++; if (parallel_sig !== '0) begin bad++; $display("[TB] FAIL reset_word cycle %0d: got %0d, required 0", c, parallel_sig); end
            total++; if (parallel_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid cycle %0d: got %b, required 0", c, parallel_valid); end
            total++; if (lock_sig !== 1'b0) begin bad++; $display("[TB] FAIL reset_lock cycle %0d: got %b, required 0", c, lock_sig); end
            total++; if (sync_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err cycle %0d: got %b, required 0", c, sync_err); end
        end
        reset_sig    = 1'b0;
        serial_valid = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(probe[i], 1'b0, 0, pv, pw, lk, se, gh);
            total++; if (lk !== 1'b0 || pv !== 1'b0) begin bad++; $display("[TB] FAIL reset_hunt bit %0d: got lock=%b valid=%b, required lock=0 valid=0", 7 - i, lk, pv); end
        end
    endtask

    task automatic test_lock_data(input int gapMax, input string tag);
        logic         pv, lk, se;
        logic [W-1:0] pw, e;
        int           gh, gap;
        doReset();
        addBits(32'(SYNC), 8, 1'b0, 1'b1, 1'b0);
        addWord(2'b10);
        addWord(2'b01);
        addWord(2'b11);
        for (int k = 0; k < stream.size(); k++) begin
            item_t it = stream[k];
            if (it.push) expQ.push_back(it.word);
            gap = (gapMax > 0) ? int'($urandom_range(gapMax, 1)) : 0;
            applyStimulus(it.b, it.rst, gap, pv, pw, lk, se, gh);
            total++; if (lk !== it.expLock) begin bad++; $display("[TB] FAIL %s_lock bit %0d: got %b, required %b", tag, k, lk, it.expLock); end
            total++; if (se !== it.expErr) begin bad++; $display("[TB] FAIL %s_err bit %0d: got %b, required %b", tag, k, se, it.expErr); end
            total++; if (pv !== it.push) begin bad++; $display("[TB] FAIL %s_valid bit %0d: got %b, required %b", tag, k, pv, it.push); end
            total++; if (gh != 0) begin bad++; $display("[TB] FAIL %s_gap bit %0d: got %0d pulses, required 0", tag, k, gh); end
            if (pv === 1'b1) begin
                total++;
                if (expQ.size() == 0) begin bad++; $display("[TB] FAIL %s_word bit %0d: got %0d, required no word", tag, k, pw); end
                else begin e = expQ.pop_front(); if (pw !== e) begin bad++; $display("[TB] FAIL %s_word bit %0d: got %0d, required %0d", tag, k, pw, e); end end
            end
        end
        total++; if (expQ.size() != 0) begin bad++; $display("[TB] FAIL %s_missing: got %0d words left, required 0", tag, expQ.size()); end
    endtask

    task automatic test_flywheel();
        logic         pv, lk, se;
        logic [W-1:0] pw, e;
        int           gh;
        doReset();
        addBits(32'(SYNC), 8, 1'b0, 1'b1, 1'b0);
        for (int f = 0; f < 5; f++) begin
            for (int w = 0; w < FRAME; w++) addWord(W'($urandom()));
            if (f == 0)      addBits(32'h00, 8, 1'b1, 1'b1, 1'b1);
            else if (f == 1) addBits(32'(SYNC), 8, 1'b1, 1'b1, 1'b0);
            else if (f < 4)  addBits(32'h00, 8, 1'b1, 1'b1, 1'b1);
        end
        for (int k = 0; k < stream.size(); k++) begin
            item_t it = stream[k];
            if (it.push) expQ.push_back(it.word);
            applyStimulus(it.b, it.rst, 0, pv, pw, lk, se, gh);
            total++; if (lk !== it.expLock) begin bad++; $display("[TB] FAIL flywheel_lock bit %0d: got %b, required %b", k, lk, it.expLock); end
            total++; if (se !== it.expErr) begin bad++; $display("[TB] FAIL flywheel_err bit %0d: got %b, required %b", k, se, it.expErr); end
            total++; if (pv !== it.push) begin bad++; $display("[TB] FAIL flywheel_valid bit %0d: got %b, required %b", k, pv, it.push); end
            if (pv === 1'b1) begin
                total++;
                if (expQ.size() == 0) begin bad++; $display("[TB] FAIL flywheel_word bit %0d: got %0d, required no word", k, pw); end
                else begin e = expQ.pop_front(); if (pw !== e) begin bad++; $display("[TB] FAIL flywheel_word bit %0d: got %0d, required %0d", k, pw, e); end end
            end
        end
        total++; if (expQ.size() != 0) begin bad++; $display("[TB] FAIL flywheel_missing: got %0d words left, required 0", expQ.size()); end
    endtask

    task automatic test_loss_of_lock();
        logic         pv, lk, se;
        logic [W-1:0] pw, e;
        int           gh;
        doReset();
        addBits(32'(SYNC), 8, 1'b0, 1'b1, 1'b0);
        for (int f = 0; f < 3; f++) begin
            for (int w = 0; w < FRAME; w++) addWord(W'($urandom()));
            // 8'hF1 followed by a single 0 would look like the sync word if
            // the hunt fill count were not restarted.
            addBits(32'hF1, 8, 1'b1, (f < 2), 1'b1);
        end
        addBits(32'h0, 1, 1'b0, 1'b0, 1'b0);
        addBits(32'(SYNC), 8, 1'b0, 1'b1, 1'b0);
        addWord(2'b01);
        addWord(2'b10);
        for (int k = 0; k < stream.size(); k++) begin
            item_t it = stream[k];
            if (it.push) expQ.push_back(it.word);
            applyStimulus(it.b, it.rst, 0, pv, pw, lk, se, gh);
            total++; if (lk !== it.expLock) begin bad++; $display("[TB] FAIL loss_lock bit %0d: got %b, required %b", k, lk, it.expLock); end
            total++; if (se !== it.expErr) begin bad++; $display("[TB] FAIL loss_err bit %0d: got %b, required %b", k, se, it.expErr); end
            total++; if (pv !== it.push) begin bad++; $display("[TB] FAIL loss_valid bit %0d: got %b, required %b", k, pv, it.push); end
            if (pv === 1'b1) begin
                total++;
                if (expQ.size() == 0) begin bad++; $display("[TB] FAIL loss_word bit %0d: got %0d, required no word", k, pw); end
                else begin e = expQ.pop_front(); if (pw !== e) begin bad++; $display("[TB] FAIL loss_word bit %0d: got %0d, required %0d", k, pw, e); end end
            end
        end
        total++; if (expQ.size() != 0) begin bad++; $display("[TB] FAIL loss_missing: got %0d words left, required 0", expQ.size()); end
    endtask

    task automatic test_reset_mid_word();
        logic         pv, lk, se;
        logic [W-1:0] pw, e;
        int           gh;
        doReset();
        addBits(32'(SYNC), 8, 1'b0, 1'b1, 1'b0);
        addBits(32'h1, 1, 1'b1, 1'b1, 1'b0);
        // This bit would complete the word 2'b10 if reset did not take priority.
        addReset(1'b0);
        addBits(32'h5, 4, 1'b0, 1'b0, 1'b0);
        addBits(32'(SYNC), 8, 1'b0, 1'b1, 1'b0);
        addWord(2'b01);
        for (int k = 0; k < stream.size(); k++) begin
            item_t it = stream[k];
            if (it.push) expQ.push_back(it.word);
            applyStimulus(it.b, it.rst, 0, pv, pw, lk, se, gh);
            total++; if (lk !== it.expLock) begin bad++; $display("[TB] FAIL midreset_lock bit %0d: got %b, required %b", k, lk, it.expLock); end
            total++; if (se !== it.expErr) begin bad++; $display("[TB] FAIL midreset_err bit %0d: got %b, required %b", k, se, it.expErr); end
            total++; if (pv !== it.push) begin bad++; $display("[TB] FAIL midreset_valid bit %0d: got %b, required %b", k, pv, it.push); end
            if (it.rst) begin
                total++; if (pw !== '0) begin bad++; $display("[TB] FAIL midreset_clear bit %0d: got %0d, required 0", k, pw); end
            end
            if (pv === 1'b1) begin
                total++;
                if (expQ.size() == 0) begin bad++; $display("[TB] FAIL midreset_word bit %0d: got %0d, required no word", k, pw); end
                else begin e = expQ.pop_front(); if (pw !== e) begin bad++; $display("[TB] FAIL midreset_word bit %0d: got %0d, required %0d", k, pw, e); end end
            end
        end
        total++; if (expQ.size() != 0) begin bad++; $display("[TB] FAIL midreset_missing: got %0d words left, required 0", expQ.size()); end
    endtask

    // Scenario sequence.
    initial begin
        $display("[TB] starting serial2parallel bench");
        test_reset();
        test_lock_data(0, "lock_data");
        test_lock_data(5, "strobe_gaps");
        test_flywheel();
        test_loss_of_lock();
        test_reset_mid_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
